// File: rtl/maxpool_bin.sv
// 2x2/stride-2 signed max-pool with binarized output, raster in, raster out, 24x24 or 8x8 maps.
// Latency 1 cycle from each odd-row/odd-col beat; no backpressure, ivalid gaps are harmless.
module maxpool_bin #(
    parameter int                    DW     = 32,
    parameter int                    W0     = 24,
    parameter int                    W1     = 8,
    parameter logic signed [DW-1:0]  THRESH = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 state,
    input  logic signed [DW-1:0] din,
    input  logic                 ivalid,
    input  logic                 idone,
    output logic signed [DW-1:0] dout,
    output logic                 bout,
    output logic                 ovalid,
    output logic                 done,
    output logic                 err
);
    localparam int CW = $clog2(W0);
    localparam int LB = W0 / 2;

    logic [CW-1:0]        r_col;
    logic [CW-1:0]        r_row;
    logic                 r_mode;
    logic signed [DW-1:0] r_hold;
    logic signed [DW-1:0] r_lbuf [LB];

    logic                 w_acc;
    logic                 w_mode;
    logic [CW-1:0]        w_wm1;
    logic                 w_last_col;
    logic                 w_final;
    logic                 w_abort;
    logic [CW-2:0]        w_idx;
    logic signed [DW-1:0] w_lb;
    logic signed [DW-1:0] w_max_hd;
    logic signed [DW-1:0] w_max_ld;

    assign w_acc      = ivalid && start;
    // Mode comes straight from the pin on the first beat, from the latched copy afterwards.
    assign w_mode     = (r_col == '0 && r_row == '0) ? state : r_mode;
    assign w_wm1      = w_mode ? CW'(W1 - 1) : CW'(W0 - 1);
    assign w_last_col = (r_col == w_wm1);
    assign w_final    = w_last_col && (r_row == w_wm1);
    assign w_abort    = idone && !w_final;
    assign w_idx      = r_col[CW-1:1];
    assign w_lb       = r_lbuf[w_idx];
    assign w_max_hd   = (din > r_hold) ? din : r_hold;
    assign w_max_ld   = (din > w_lb)   ? din : w_lb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 1'b0;
            r_hold <= '0;
            dout   <= '0;
            bout   <= 1'b0;
            ovalid <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            done   <= 1'b0;
            if (!start) begin
                r_col  <= '0;
                r_row  <= '0;
                r_mode <= 1'b0;
                r_hold <= '0;
            end else if (w_acc) begin
                if (idone != w_final)
                    err <= 1'b1;
                case ({r_row[0], r_col[0]})
                    2'b00: r_hold <= din;
                    2'b10: r_hold <= w_max_ld;
                    2'b11: begin
                        dout   <= w_max_hd;
                        bout   <= (w_max_hd >= THRESH);
                        ovalid <= 1'b1;
                        done   <= w_final;
                    end
                    default: ;
                endcase
                if (w_final || w_abort) begin
                    r_col  <= '0;
                    r_row  <= '0;
                    r_mode <= 1'b0;
                end else begin
                    r_mode <= w_mode;
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + CW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
            end
        end
    end

    // Pair maxima of even rows; every entry is rewritten before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_acc && !r_row[0] && r_col[0])
            r_lbuf[w_idx] <= w_max_hd;
    end
endmodule
